// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// the NOP word used for faulted fetches and the default bus width.
package if_fetch_ctrl_pkg;

    localparam int          ADDR_W_DEF = 32;
    localparam logic [31:0] NOP_INST   = 32'h0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_WAIT    = 3'd2,
        S_HOLD    = 3'd3,
        S_DISCARD = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_inst_buf.sv
// One-entry output buffer holding {pc, inst, adel} for the decode stage.
// A load sets valid; a clear drops valid but keeps the last contents.
module if_inst_buf
    import if_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hbfc0_0000)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_inst,
    input  logic              i_adel,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_inst,
    output logic              o_adel
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inst;
    logic              r_adel;

    // Load has priority so a refill in the same cycle as a clear keeps the new entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_inst  <= ADDR_W'(NOP_INST);
            r_adel  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_adel  <= i_adel;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_adel  = r_adel;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding read on the inst bus, PC
// advance via pc_en, and dropping of in-flight fetches on a flush.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hbfc0_0000)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_pc_en,
    input  logic              i_flush,
    output logic              o_inst_req,
    output logic [ADDR_W-1:0] o_inst_addr,
    input  logic              i_inst_addr_ok,
    input  logic              i_inst_data_ok,
    input  logic [ADDR_W-1:0] i_inst_rdata,
    input  logic              i_id_ready,
    output logic              o_if_valid,
    output logic [ADDR_W-1:0] o_if_pc,
    output logic [ADDR_W-1:0] o_if_inst,
    output logic              o_if_adel
);

    fetch_state_t      r_state;
    fetch_state_t      w_stateNext;
    logic [ADDR_W-1:0] r_reqAddr;
    logic              w_aligned;
    logic              w_handshake;
    logic              w_bufLoad;
    logic              w_bufClear;
    logic [ADDR_W-1:0] w_loadPc;
    logic [ADDR_W-1:0] w_loadInst;
    logic              w_loadAdel;

    assign w_aligned   = (i_pc[1:0] == 2'b00);
    assign w_handshake = (r_state == S_REQ) && w_aligned && i_inst_addr_ok;
    assign o_inst_addr = i_pc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_reqAddr <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_handshake) begin
                r_reqAddr <= i_pc;
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        o_inst_req  = 1'b0;
        o_pc_en     = 1'b0;
        w_bufLoad   = 1'b0;
        w_bufClear  = 1'b0;
        w_loadPc    = i_pc;
        w_loadInst  = ADDR_W'(NOP_INST);
        w_loadAdel  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_stateNext = S_REQ;
            end
            S_REQ: begin
                o_inst_req = w_aligned;
                if (i_flush) begin
                    // Redirect wins; an accepted request must still be drained.
                    o_pc_en = 1'b1;
                    if (w_handshake) begin
                        w_stateNext = S_DISCARD;
                    end
                end else if (w_aligned) begin
                    if (i_inst_addr_ok) begin
                        o_pc_en     = 1'b1;
                        w_stateNext = S_WAIT;
                    end
                end else begin
                    w_bufLoad   = 1'b1;
                    w_loadAdel  = 1'b1;
                    w_stateNext = S_HOLD;
                end
            end
            S_WAIT: begin
                o_pc_en = i_flush;
                if (i_inst_data_ok) begin
                    if (i_flush) begin
                        w_stateNext = S_REQ;
                    end else begin
                        w_bufLoad   = 1'b1;
                        w_loadPc    = r_reqAddr;
                        w_loadInst  = i_inst_rdata;
                        w_stateNext = S_HOLD;
                    end
                end else if (i_flush) begin
                    w_stateNext = S_DISCARD;
                end
            end
            S_HOLD: begin
                o_pc_en = i_flush;
                if (i_flush || i_id_ready) begin
                    w_bufClear  = 1'b1;
                    w_stateNext = S_REQ;
                end
            end
            S_DISCARD: begin
                // The stale response is swallowed even when another flush arrives.
                o_pc_en = i_flush;
                if (i_inst_data_ok) begin
                    w_stateNext = S_REQ;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    if_inst_buf #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_inst_buf (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_bufLoad),
        .i_clear(w_bufClear),
        .i_pc   (w_loadPc),
        .i_inst (w_loadInst),
        .i_adel (w_loadAdel),
        .o_valid(o_if_valid),
        .o_pc   (o_if_pc),
        .o_inst (o_if_inst),
        .o_adel (o_if_adel)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios then random bus/flush traffic,
// all checked against a transaction-level model of the fetch unit.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcReg;
    logic        pcEn;
    logic        flush;
    logic        instReq;
    logic [31:0] instAddr;
    logic        addrOk;
    logic        dataOk;
    logic [31:0] rdata;
    logic        idReady;
    logic        ifValid;
    logic [31:0] ifPc;
    logic [31:0] ifInst;
    logic        ifAdel;

    int checks = 0;
    int errors = 0;

    // Model: a fetch unit that has started, may have one read in flight
    // (possibly marked to be dropped) and a one-entry buffer for decode.
    bit          mStarted;
    bit          mOutstanding;
    bit          mDrop;
    bit          mBufValid;
    bit          mBufAdel;
    logic [31:0] mBufPc;
    logic [31:0] mBufInst;
    logic [31:0] mCapAddr;

    bit busPending;
    int busDelay;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pc          (pcReg),
        .o_pc_en       (pcEn),
        .i_flush       (flush),
        .o_inst_req    (instReq),
        .o_inst_addr   (instAddr),
        .i_inst_addr_ok(addrOk),
        .i_inst_data_ok(dataOk),
        .i_inst_rdata  (rdata),
        .i_id_ready    (idReady),
        .o_if_valid    (ifValid),
        .o_if_pc       (ifPc),
        .o_if_inst     (ifInst),
        .o_if_adel     (ifAdel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit expReq();
        return mStarted && !mOutstanding && !mBufValid && (pcReg[1:0] == 2'b00);
    endfunction

    task automatic checkOutput(input bit expPcEn);
        chk("inst_req", {31'b0, instReq}, {31'b0, expReq()});
        chk("inst_addr", instAddr, pcReg);
        chk("pc_en", {31'b0, pcEn}, {31'b0, expPcEn});
        chk("if_valid", {31'b0, ifValid}, {31'b0, mBufValid});
        chk("if_pc", ifPc, mBufPc);
        chk("if_inst", ifInst, mBufInst);
        chk("if_adel", {31'b0, ifAdel}, {31'b0, mBufAdel});
    endtask

    // One clock: drive at negedge, check shortly after, advance model after posedge.
    task automatic applyStimulus(input bit rstV, input bit flushV, input bit aokV,
                                 input bit dokV, input logic [31:0] rdataV,
                                 input bit idrV, input logic [31:0] targetV);
        bit          req;
        bit          expPcEn;
        logic [31:0] oldPc;
        @(negedge clk);
        rst     = rstV;
        flush   = flushV;
        addrOk  = aokV;
        dataOk  = dokV;
        rdata   = rdataV;
        idReady = idrV;
        #1;
        req     = expReq();
        expPcEn = mStarted && (flushV || (req && aokV));
        checkOutput(expPcEn);
        @(posedge clk);
        #1;
        oldPc = pcReg;
        if (rstV) begin
            mStarted     = 0;
            mOutstanding = 0;
            mDrop        = 0;
            mBufValid    = 0;
            mBufAdel     = 0;
            mBufPc       = RESET_PC;
            mBufInst     = 32'h0;
            pcReg        = RESET_PC;
        end else begin
            if (!mStarted) begin
                mStarted = 1;
            end else if (mOutstanding) begin
                if (dokV) begin
                    if (!mDrop && !flushV) begin
                        mBufValid = 1;
                        mBufPc    = mCapAddr;
                        mBufInst  = rdataV;
                        mBufAdel  = 0;
                    end
                    mOutstanding = 0;
                    mDrop        = 0;
                end else if (flushV) begin
                    mDrop = 1;
                end
            end else if (mBufValid) begin
                if (idrV || flushV) mBufValid = 0;
            end else if (oldPc[1:0] == 2'b00) begin
                if (aokV) begin
                    mOutstanding = 1;
                    mCapAddr     = oldPc;
                    mDrop        = flushV;
                end
            end else if (!flushV) begin
                mBufValid = 1;
                mBufPc    = oldPc;
                mBufInst  = 32'h0;
                mBufAdel  = 1;
            end
            if (expPcEn) pcReg = flushV ? targetV : oldPc + 32'd4;
        end
    endtask

    initial begin
        bit          rstV, flushV, aokV, dokV, idrV;
        logic [31:0] tmp;
        logic [31:0] target;

        rst = 1'b1; flush = 1'b0; addrOk = 1'b0; dataOk = 1'b0;
        rdata = 32'h0; idReady = 1'b0; pcReg = RESET_PC;
        mStarted = 0; mOutstanding = 0; mDrop = 0; mBufValid = 0; mBufAdel = 0;
        mBufPc = RESET_PC; mBufInst = 32'h0; mCapAddr = 32'h0;

        $display("[TB] reset and first fetch");
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("rst_if_pc", ifPc, RESET_PC);
        chk("rst_if_valid", {31'b0, ifValid}, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'h1234_5678, 0, 32'h0);
        chk("t1_valid", {31'b0, ifValid}, 32'h1);
        chk("t1_inst", ifInst, 32'h1234_5678);
        chk("t1_pc", ifPc, 32'hbfc0_0000);

        $display("[TB] decode stall");
        repeat (5) applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("t2_inst", ifInst, 32'h1234_5678);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h0);
        chk("t2_req", {31'b0, instReq}, 32'h1);
        chk("t2_addr", instAddr, 32'hbfc0_0004);

        $display("[TB] flush in WAIT");
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'hbfc0_0380);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'hdead_beef, 0, 32'h0);
        chk("t3_valid", {31'b0, ifValid}, 32'h0);
        chk("t3_addr", instAddr, 32'hbfc0_0380);
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 1, 32'hcafe_0001, 0, 32'h0);
        chk("t3_inst", ifInst, 32'hcafe_0001);
        chk("t3_pc", ifPc, 32'hbfc0_0380);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h0);

        $display("[TB] flush with addr_ok");
        applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'hbfc0_0400);
        applyStimulus(0, 0, 0, 1, 32'hbad0_bad0, 0, 32'h0);
        chk("t4_valid", {31'b0, ifValid}, 32'h0);
        chk("t4_inst", ifInst, 32'hcafe_0001);

        $display("[TB] misaligned pc");
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'hbfc0_0002);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);
        chk("t5_adel", {31'b0, ifAdel}, 32'h1);
        chk("t5_inst", ifInst, 32'h0);
        chk("t5_pc", ifPc, 32'hbfc0_0002);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'hbfc0_0500);
        chk("t5_clear", {31'b0, ifValid}, 32'h0);

        $display("[TB] reset in WAIT");
        applyStimulus(0, 0, 1, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 1, 32'h5555_aaaa, 0, 32'h0);
        chk("t6_pc", ifPc, RESET_PC);
        chk("t6_inst", ifInst, 32'h0);
        chk("t6_req", {31'b0, instReq}, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h0);

        $display("[TB] random traffic");
        busPending = 0;
        busDelay   = 0;
        for (int i = 0; i < 3000; i++) begin
            rstV   = ($urandom % 200) == 0;
            flushV = ($urandom % 10) == 0;
            tmp    = $urandom;
            target = {tmp[31:2], 2'b00};
            if (($urandom % 8) == 0) target[1:0] = 2'b10;
            aokV = expReq() && (($urandom % 3) == 0);
            if (busPending) dokV = (busDelay == 0);
            else            dokV = ($urandom % 16) == 0;
            idrV = ($urandom % 2) == 0;
            applyStimulus(rstV, flushV, aokV, dokV, $urandom, idrV, target);
            if (rstV) begin
                busPending = 0;
            end else begin
                if (busPending) begin
                    if (busDelay == 0) busPending = 0;
                    else               busDelay--;
                end
                if (aokV) begin
                    busPending = 1;
                    busDelay   = int'($urandom % 3);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
